// File: rtl/dct_pkg.sv
// Shared definitions for the DCT transpose buffer.
// Block geometry, default sample width, bank and read-FSM states.
package dct_pkg;

  localparam int DIM      = 8;
  localparam int SIZE_OUT = 11;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FULL,
    B_DRAINING
  } bank_st_t;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_st_t;

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 register bank of the transpose buffer.
// Whole-block write, combinational read of one column.
module dct_tbuf_bank #(
  parameter int W = dct_pkg::SIZE_OUT,
  parameter int N = dct_pkg::DIM
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [N-1:0][N-1:0][W-1:0]  din,
  input  logic [$clog2(N)-1:0]        col_sel,
  output logic [N-1:0][W-1:0]         col
);
  import dct_pkg::*;

  logic [N-1:0][N-1:0][W-1:0] mem;

  // capture the full row-stage block in one edge
  always_ff @(posedge clk) begin
    if (we) mem <= din;
  end

  // select column col_sel across all rows
  always_comb begin
    col = '0;
    for (int r = 0; r < N; r++) begin
      col[r] = mem[r][col_sel];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the DCT row and column stages.
// Stores whole blocks, streams them out column by column.
module dct_transpose_buf #(
  parameter int SIZE_OUT = dct_pkg::SIZE_OUT,
  parameter int DIM      = dct_pkg::DIM
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic signed [DIM-1:0][DIM-1:0][SIZE_OUT-1:0] block_in,
  input  logic                                      block_valid,
  input  logic                                      col_ready,
  output logic signed [DIM-1:0][SIZE_OUT-1:0]       col_out,
  output logic                                      col_valid,
  output logic                                      col_first,
  output logic                                      col_last,
  output logic                                      overflow
);
  import dct_pkg::*;

  localparam int CW = $clog2(DIM);

  typedef logic signed [DIM-1:0][SIZE_OUT-1:0] col_t;

  bank_st_t        bank_st [2];
  bank_st_t        mid     [2];
  rd_st_t          rd_st;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            rd_nxt;
  logic [CW-1:0]   col_idx;
  logic            accept;
  logic            done;
  logic            free_wr;
  logic            capture;
  logic            start;
  logic [1:0]      we;
  col_t            bank_col [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign we[gi] = capture && !rst && (wr_ptr == 1'(gi));
    dct_tbuf_bank #(
      .W (SIZE_OUT),
      .N (DIM)
    ) u_bank (
      .clk     (clk),
      .we      (we[gi]),
      .din     (block_in),
      .col_sel (col_idx),
      .col     (bank_col[gi])
    );
  end

  assign col_valid = (rd_st == RD_STREAM);

  // handshake, capture decision and next bank states
  always_comb begin
    accept  = col_valid && col_ready;
    done    = accept && (col_idx == CW'(DIM - 1));
    free_wr = (bank_st[wr_ptr] == B_EMPTY)
           || (done && (rd_ptr == wr_ptr));
    capture = block_valid && free_wr;
    rd_nxt  = rd_ptr ^ done;
    for (int i = 0; i < 2; i++) begin
      mid[i] = bank_st[i];
      if (done && rd_ptr == 1'(i))    mid[i] = B_EMPTY;
      if (capture && wr_ptr == 1'(i)) mid[i] = B_FULL;
    end
    start = ((rd_st == RD_IDLE) || done)
         && (mid[rd_nxt] == B_FULL);
  end

  // bank bookkeeping, pointers, read FSM and overflow strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_st      <= RD_IDLE;
      col_idx    <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bank_st[i] <= mid[i];
      end
      if (start) bank_st[rd_nxt] <= B_DRAINING;
      wr_ptr <= wr_ptr ^ capture;
      rd_ptr <= rd_nxt;
      if (start)     rd_st <= RD_STREAM;
      else if (done) rd_st <= RD_IDLE;
      if (accept) col_idx <= done ? '0 : col_idx + CW'(1);
      overflow <= block_valid && !free_wr;
    end
  end

  // column mux, forced to zero when nothing is presented
  always_comb begin
    col_out   = '0;
    col_first = 1'b0;
    col_last  = 1'b0;
    if (col_valid) begin
      col_out   = rd_ptr ? bank_col[1] : bank_col[0];
      col_first = (col_idx == '0);
      col_last  = (col_idx == CW'(DIM - 1));
    end
  end

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 The block SHALL have parameter SIZE_OUT, default 11, giving the signed sample width of the row-stage result.
REQ-002 The block SHALL have parameter DIM, default 8, giving the block dimension; only 8 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port block_in, input, [DIM-1:0][DIM-1:0] x SIZE_OUT signed: the row-stage result matrix, indexed [row][col].
REQ-006 The block SHALL have port block_valid, input, 1 bit: a one-cycle pulse meaning block_in is valid this cycle; it is driven by the row stage's done strobe.
REQ-007 The block SHALL have port col_ready, input, 1 bit: the column stage accepts col_out this cycle.
REQ-008 The block SHALL have port col_out, output, [DIM-1:0] x SIZE_OUT signed: one column of the stored block.
REQ-009 The block SHALL have port col_valid, output, 1 bit: col_out is valid.
REQ-010 The block SHALL have port col_first, output, 1 bit: asserted with column 0; it is the column stage's dct_en.
REQ-011 The block SHALL have port col_last, output, 1 bit: asserted with column 7.
REQ-012 The block SHALL have port overflow, output, 1 bit: a one-cycle pulse meaning a block was dropped.

Function
REQ-013 The block SHALL hold two 8x8 banks (ping-pong); each bank state SHALL be one of EMPTY, FULL or DRAINING.
REQ-014 On block_valid, the block SHALL capture block_in into the write bank at that edge if that bank is EMPTY; the write pointer SHALL then toggle.
REQ-015 Column k of a block SHALL be output as col_out[r] = stored[r][k] for r = 0..7, and columns SHALL be sent in the order k = 0..7.
REQ-016 The read FSM SHALL have states IDLE and STREAM. IDLE goes to STREAM when the read bank is FULL. STREAM returns to IDLE after column 7 is accepted, unless the other bank is FULL, in which case it continues without a gap.
REQ-017 A column SHALL be accepted when col_valid and col_ready are both high; the column index SHALL advance only on acceptance. col_out, col_first and col_last SHALL be held stable while col_valid is high and col_ready is low.
REQ-018 Latency SHALL be as follows: block_valid at edge N with the FSM IDLE gives col_valid=1 with column 0 in cycle N+1. With col_ready held high, the 8 columns occupy cycles N+1..N+8.
REQ-019 On acceptance of column 7, the bank SHALL become EMPTY at that edge and the read pointer SHALL toggle.
REQ-020 When block_valid arrives while both banks are non-EMPTY, the block SHALL drop block_in, pulse overflow in the next cycle and leave the stored data unchanged. The one exception: if the write bank frees in the same cycle through a column-7 acceptance, the capture SHALL succeed and there SHALL be no overflow.
REQ-021 When col_valid is 0, col_out, col_first and col_last SHALL be 0.
REQ-022 Data SHALL pass through bit-exact, with no rounding, saturation or width change.

Reset
REQ-023 With rst high at a clock edge, both banks SHALL become EMPTY, both pointers SHALL be set to bank 0, the FSM SHALL go to IDLE and the column index SHALL be set to 0.
REQ-024 After reset, all outputs (col_out, col_valid, col_first, col_last, overflow) SHALL read 0; bank contents need not be cleared.
REQ-025 A reset during STREAM SHALL abandon the block in progress; col_valid SHALL be 0 in the cycle after the reset edge.
REQ-026 A block_valid coincident with rst SHALL be ignored.

Structure
REQ-027 Shared package dct_pkg SHALL hold DIM, the default SIZE_OUT, and the bank-state and read-FSM enum typedefs.
REQ-028 One sub-module, dct_tbuf_bank, SHALL implement the 8x8 register bank with write-all and read-column-k ports, instantiated twice.

Verification
REQ-029 Single block, ramp stimulus (block_in[r][c] = 8r+c), col_ready=1 -> col_out[r] = 8r+k in cycles N+1..N+8; col_first only in N+1; col_last only in N+8.
REQ-030 Back-to-back blocks with block_valid every 8 cycles, as the row stage produces them -> 64 columns, no gap between blocks, no overflow, both banks alternate.
REQ-031 col_ready low for 3 cycles during column 2 -> column 2 held stable; the columns still total 8 and stay in order.
REQ-032 Three blocks within 3 cycles with col_ready=0 -> the third is dropped; overflow pulses once; the first two drain intact after col_ready rises.
REQ-033 Column-7 acceptance and block_valid in the same cycle with both banks non-EMPTY -> the capture succeeds and overflow stays 0.
REQ-034 rst asserted at column 4 -> col_valid=0 in the next cycle; the next block starts at column 0 from bank 0; extreme values -1024 and 1023 pass through unchanged.
